// File: rtl/byte_data_memory_pkg.sv
// Shared types for the byte-addressable data memory: load/store size encodings and clear FSM states.
package mem_pkg;

  localparam int unsigned LANE_W = 8;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

endpackage

// File: rtl/byte_data_memory_if.sv
// Core-side load/store bus of byte_data_memory.
interface byte_data_memory_if;
  logic        WE;
  logic [31:0] A;
  logic [31:0] WD;
  logic [2:0]  funct3;
  logic [31:0] RD;
  logic        busy;
  logic        oor;
  logic        misalign;

  modport master (output WE, A, WD, funct3, input RD, busy, oor, misalign);
  modport slave  (input WE, A, WD, funct3, output RD, busy, oor, misalign);
endinterface

// File: rtl/byte_data_memory_load_extend.sv
// Picks the addressed byte/half/word out of a memory word and sign/zero extends it per funct3.
module load_extend
  import mem_pkg::*;
(
  input  logic [3:0][LANE_W-1:0] word,
  input  logic [1:0]             lane,
  input  logic [2:0]             funct3,
  output logic [31:0]            data
);

  logic [LANE_W-1:0]   sel_b;
  logic [2*LANE_W-1:0] sel_h;

  always_comb begin
    sel_b = word[lane];
    sel_h = lane[1] ? {word[3], word[2]} : {word[1], word[0]};
    data  = '0;
    case (funct3)
      MEM_B:   data = {{24{sel_b[LANE_W-1]}}, sel_b};
      MEM_BU:  data = {24'h0, sel_b};
      MEM_H:   data = {{16{sel_h[2*LANE_W-1]}}, sel_h};
      MEM_HU:  data = {16'h0, sel_h};
      MEM_W:   data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/byte_data_memory.sv
// RV32I data memory with byte-lane stores, extended loads, post-reset clear sequencer and range check.
// Optional macro MEM_MISALIGN_TRAP_EN: flag and suppress misaligned half/word accesses instead of aligning them.
module byte_data_memory
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  byte_data_memory_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [3:0][LANE_W-1:0] mem [0:DEPTH-1];

  clr_state_e state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;

  logic [31:0] offset;
  logic [AW-1:0] idx;
  logic [1:0]  lane, eff_lane;
  logic        in_range, mis, busy;
  logic [3:0]  be;
  logic [3:0][LANE_W-1:0] wdata;
  logic [AW-1:0] wr_idx;
  logic [31:0] ext;

  // BASE_ADDR is window-aligned, so the low offset bits equal A[1:0].
  assign offset   = bus.A - BASE_ADDR;
  assign idx      = offset[AW+1:2];
  assign lane     = offset[1:0];
  assign in_range = offset < 32'(DEPTH * 4);
  assign busy     = (state == CLEAR);

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    mis      = 1'b0;
    eff_lane = lane;
    case (bus.funct3)
      MEM_H, MEM_HU: mis = lane[0];
      MEM_W:         mis = |lane;
      default:       mis = 1'b0;
    endcase
  end
`else
  always_comb begin
    mis      = 1'b0;
    eff_lane = lane;
    case (bus.funct3)
      MEM_H, MEM_HU: eff_lane = {lane[1], 1'b0};
      MEM_W:         eff_lane = 2'b00;
      default:       eff_lane = lane;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    if (state == CLEAR) begin
      ptr_nxt = ptr + 1'b1;
      if (ptr == AW'(DEPTH - 1)) state_nxt = READY;
    end
  end

  // Single write port shared by the clear sequencer and core stores.
  always_comb begin
    be     = '0;
    wdata  = '0;
    wr_idx = idx;
    if (state == CLEAR) begin
      be     = 4'hF;
      wdata  = CLEAR_VALUE;
      wr_idx = ptr;
    end else if (bus.WE && in_range && !mis) begin
      case (bus.funct3)
        MEM_B: begin
          be    = 4'b0001 << eff_lane;
          wdata = {4{bus.WD[7:0]}};
        end
        MEM_H: begin
          be    = 4'b0011 << eff_lane;
          wdata = {2{bus.WD[15:0]}};
        end
        MEM_W: begin
          be    = 4'hF;
          wdata = bus.WD;
        end
        default: be = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) mem[wr_idx][i] <= wdata[i];
    end
  end

  load_extend u_load_extend (
    .word   (mem[idx]),
    .lane   (eff_lane),
    .funct3 (bus.funct3),
    .data   (ext)
  );

  assign bus.RD       = (busy || !in_range || mis) ? '0 : ext;
  assign bus.busy     = busy;
  assign bus.oor      = !in_range;
  assign bus.misalign = mis;

endmodule

// File: tb/tb_byte_data_memory.sv
// Randomized self-checking bench for byte_data_memory against a byte-array reference model.
module tb_byte_data_memory;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned MEMB  = DEPTH * 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] CLRV  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic chk_en = 1'b0;

  byte_data_memory_if bus ();

  byte_data_memory #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CLEAR_VALUE(CLRV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: flat little-endian byte array plus count of clear cycles remaining.
  logic [7:0]  mm [MEMB];
  int unsigned clear_left = DEPTH;

  function automatic logic exp_mis(logic [31:0] a, logic [2:0] f3);
`ifdef MEM_MISALIGN_TRAP_EN
    return ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
`else
    return (a[0] && 1'b0) || (f3 == 3'd7 && 1'b0);
`endif
  endfunction

  function automatic logic exp_oor(logic [31:0] a);
    return (a - BASE) >= MEMB;
  endfunction

  function automatic logic [31:0] exp_rd(logic [31:0] a, logic [2:0] f3, logic bsy);
    int unsigned o;
    logic [7:0]  b;
    logic [15:0] h;
    if (bsy || exp_oor(a) || exp_mis(a, f3)) return 32'h0;
    o = a - BASE;
    case (f3)
      3'd0, 3'd4: begin
        b = mm[o];
        return (f3 == 3'd0) ? {{24{b[7]}}, b} : {24'h0, b};
      end
      3'd1, 3'd5: begin
        o = o & ~32'd1;
        h = {mm[o+1], mm[o]};
        return (f3 == 3'd1) ? {{16{h[15]}}, h} : {16'h0, h};
      end
      3'd2: begin
        o = o & ~32'd3;
        return {mm[o+3], mm[o+2], mm[o+1], mm[o]};
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_store(logic [31:0] a, logic [31:0] wd, logic [2:0] f3);
    int unsigned o;
    if (exp_oor(a) || exp_mis(a, f3)) return;
    o = a - BASE;
    case (f3)
      3'd0: mm[o] = wd[7:0];
      3'd1: begin
        o = o & ~32'd1;
        mm[o] = wd[7:0]; mm[o+1] = wd[15:8];
      end
      3'd2: begin
        o = o & ~32'd3;
        for (int unsigned i = 0; i < 4; i++) mm[o+i] = wd[8*i +: 8];
      end
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      clear_left = DEPTH;
    end else if (clear_left != 0) begin
      for (int unsigned i = 0; i < 4; i++) mm[4*(DEPTH-clear_left)+i] = CLRV[8*i +: 8];
      clear_left = clear_left - 1;
    end else if (bus.WE) begin
      model_store(bus.A, bus.WD, bus.funct3);
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (A=%h f3=%0d t=%0t)", name, act, exp, bus.A, bus.funct3, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic eb;
      eb = !rst || (clear_left != 0);
      check("busy", {31'h0, bus.busy}, {31'h0, eb});
      check("oor", {31'h0, bus.oor}, {31'h0, exp_oor(bus.A)});
      check("misalign", {31'h0, bus.misalign}, {31'h0, exp_mis(bus.A, bus.funct3)});
      check("rd", bus.RD, exp_rd(bus.A, bus.funct3, eb));
    end
  end

  task automatic drive(logic we, logic [31:0] a, logic [31:0] wd, logic [2:0] f3);
    @(negedge clk);
    #1;
    bus.WE = we; bus.A = a; bus.WD = wd; bus.funct3 = f3;
  endtask

  task automatic count_busy(string name, logic pulses);
    int n = 0;
    while (bus.busy && n < 400) begin
      if (pulses) begin
        bus.WE = 1'($urandom_range(0, 1));
        bus.A  = BASE + 32'($urandom_range(0, 255));
        bus.WD = $urandom;
        bus.funct3 = 3'($urandom_range(0, 2));
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.WE = 1'b0;
    check(name, 32'(n), 32'd256);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.WE = 1'b0; bus.A = BASE; bus.WD = '0; bus.funct3 = 3'd2;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("reset_busy", {31'h0, bus.busy}, 32'd1);
    check("reset_rd", bus.RD, 32'h0);

    // Clear length and all-zero contents
    @(negedge clk); #1 rst = 1'b1;
    count_busy("clear_len", 1'b0);
    for (int w = 0; w < int'(DEPTH); w++) begin
      drive(1'b0, BASE + 32'(4*w), '0, 3'd2);
      #1 check("cleared_word", bus.RD, 32'h0);
    end

    // Extended loads after a word store
    drive(1'b1, 32'h10, 32'hDEADBEEF, 3'd2);
    drive(1'b0, 32'h13, '0, 3'd0); #1 check("lb_13", bus.RD, 32'hFFFFFFDE);
    drive(1'b0, 32'h10, '0, 3'd4); #1 check("lbu_10", bus.RD, 32'h000000EF);
    drive(1'b0, 32'h12, '0, 3'd1); #1 check("lh_12", bus.RD, 32'hFFFFDEAD);
    drive(1'b0, 32'h10, '0, 3'd5); #1 check("lhu_10", bus.RD, 32'h0000BEEF);

    // Partial stores
    drive(1'b1, 32'h11, 32'h00000055, 3'd0);
    drive(1'b0, 32'h10, '0, 3'd2); #1 check("sb_merge", bus.RD, 32'hDEAD55EF);
    drive(1'b1, 32'h12, 32'h00001234, 3'd1);
    drive(1'b0, 32'h10, '0, 3'd2); #1 check("sh_merge", bus.RD, 32'h123455EF);

    // Out of range: aliases word 0 if not gated
    drive(1'b0, BASE + 32'h400, '0, 3'd2);
    #1 check("oor_flag", {31'h0, bus.oor}, 32'd1);
    check("oor_rd", bus.RD, 32'h0);
    drive(1'b1, BASE + 32'h400, 32'h11111111, 3'd2);
    drive(1'b0, BASE, '0, 3'd2); #1 check("oor_no_write", bus.RD, 32'h0);

    // Misaligned word store
    drive(1'b1, 32'h12, 32'hCAFEF00D, 3'd2);
`ifdef MEM_MISALIGN_TRAP_EN
    #1 check("mis_flag", {31'h0, bus.misalign}, 32'd1);
    drive(1'b0, 32'h10, '0, 3'd2); #1 check("mis_no_write", bus.RD, 32'h123455EF);
`else
    #1 check("mis_flag", {31'h0, bus.misalign}, 32'd0);
    drive(1'b0, 32'h10, '0, 3'd2); #1 check("mis_aligned_write", bus.RD, 32'hCAFEF00D);
`endif

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = BASE + 32'($urandom_range(32'h3F0, 32'h40F));
        default: a = BASE + 32'($urandom_range(0, 63));
      endcase
      drive(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)));
    end

    // Reset in READY, then again mid-clear at ptr=100, with store pulses during busy
    drive(1'b0, BASE, '0, 3'd2);
    @(negedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    repeat (100) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    count_busy("restart_len", 1'b1);
    drive(1'b0, 32'h10, '0, 3'd2); #1 check("post_restart_10", bus.RD, 32'h0);
    for (int w = 0; w < 64; w++) drive(1'b0, BASE + 32'(4*w), '0, 3'd2);

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
